// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, one bit per cycle.
// Optional macro MULTDIV_UNSIGNED_EN adds is_unsigned for multu/divu.
module mult_div_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ITER_CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = WIDTH + 1;
  localparam logic [ITER_CNT_W-1:0] LAST_CNT = ITER_CNT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [ITER_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]        opnd_q, opnd_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0]        low_q, low_d;
  logic                    extra_q, extra_d;
  logic                    sign_a_q, sign_a_d;
  logic                    sign_b_q, sign_b_d;
  logic                    dz_q, dz_d;
  logic                    uns_q, uns_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    div_zero_q, div_zero_d;
  logic [WIDTH-1:0]        hi_q, hi_d;
  logic [WIDTH-1:0]        lo_q, lo_d;

  logic                    uns_in;
  logic [WIDTH-1:0]        a_mag, b_mag;
  logic [ACC_W-1:0]        mul_sum;
  logic                    mul_fill;
  logic [ACC_W-1:0]        r_sh, diff;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

`ifdef MULTDIV_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign a_mag = (a[WIDTH-1] && !uns_in) ? neg(a) : a;
  assign b_mag = (b[WIDTH-1] && !uns_in) ? neg(b) : b;

  // Multiply step: Booth recoding when signed, plain shift-and-add when unsigned.
  // The accumulator carries one guard bit so -A of the most negative A cannot overflow.
  always_comb begin
    mul_sum = acc_q;
    if (uns_q) begin
      if (low_q[0]) mul_sum = acc_q + {1'b0, opnd_q};
    end else begin
      case ({low_q[0], extra_q})
        2'b01:   mul_sum = acc_q + {opnd_q[WIDTH-1], opnd_q};
        2'b10:   mul_sum = acc_q - {opnd_q[WIDTH-1], opnd_q};
        default: mul_sum = acc_q;
      endcase
    end
    mul_fill = uns_q ? 1'b0 : mul_sum[ACC_W-1];
  end

  // Divide step: shifted partial remainder and trial subtraction.
  assign r_sh = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
  assign diff = r_sh - {1'b0, opnd_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    low_d      = low_q;
    extra_d    = extra_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_d       = dz_q;
    uns_d      = uns_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          uns_d   = uns_in;
          opnd_d  = a;
          acc_d   = '0;
          low_d   = b;
          extra_d = 1'b0;
          cnt_d   = '0;
          state_d = S_MULT;
        end else if (start_div) begin
          uns_d    = uns_in;
          sign_a_d = a[WIDTH-1] & ~uns_in;
          sign_b_d = b[WIDTH-1] & ~uns_in;
          opnd_d   = b_mag;
          acc_d    = '0;
          low_d    = a_mag;
          dz_d     = (b == '0);
          // A zero divisor skips straight to the finishing step.
          cnt_d    = (b == '0) ? LAST_CNT : '0;
          state_d  = S_DIV;
        end
      end
      S_MULT: begin
        if (cnt_q == LAST_CNT) begin
          hi_d    = acc_q[WIDTH-1:0];
          lo_d    = low_q;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d   = {mul_fill, mul_sum[ACC_W-1:1]};
          low_d   = {mul_sum[0], low_q[WIDTH-1:1]};
          extra_d = low_q[0];
          cnt_d   = cnt_q + ITER_CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == LAST_CNT) begin
          if (dz_q) begin
            div_zero_d = 1'b1;
          end else begin
            lo_d = (sign_a_q ^ sign_b_q) ? neg(low_q) : low_q;
            hi_d = sign_a_q ? neg(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
          end
          dz_d    = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d = diff[ACC_W-1] ? r_sh : diff;
          low_d = {low_q[WIDTH-2:0], ~diff[ACC_W-1]};
          cnt_d = cnt_q + ITER_CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      low_q      <= '0;
      extra_q    <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_q       <= 1'b0;
      uns_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      low_q      <= low_d;
      extra_q    <= extra_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dz_q       <= dz_d;
      uns_q      <= uns_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiply/divide responder for the MIPS multicycle datapath. It serves the control unit: the control unit pulses a start, waits on busy/done, then latches the results into Hi/Lo through HiWrite/LoWrite. The unit computes the MIPS mult and div semantics iteratively, one bit per cycle, which keeps the control FSM free of arithmetic timing.

Parameters:
WIDTH, 32, operand width. Hi and lo are each WIDTH bits.
ITER_CNT_W, 6, width of the iteration counter. Must satisfy 2^ITER_CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start_mult  input  1  request a signed multiply; sampled only in IDLE
start_div  input  1  request a signed divide; sampled only in IDLE
a  input  WIDTH  operand A (multiplicand or dividend); captured at start
b  input  WIDTH  operand B (multiplier or divisor); captured at start
busy  output  1  high while the unit is in MULT, DIV or DONE
done  output  1  one-cycle pulse when hi/lo are valid
div_zero  output  1  one-cycle pulse, coincident with done, on a divide by zero
hi  output  WIDTH  mult: product[2W-1:W]; div: remainder
lo  output  WIDTH  mult: product[W-1:0]; div: quotient

Behaviour:
- Reset is synchronous and active-high on clk. On reset: state=IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0, lo=0, and all internal working registers are cleared.
- Reset overrides everything, including an operation in progress. After the reset edge the unit is IDLE and no done pulse is produced for the aborted operation.
- States are IDLE, MULT, DIV and DONE.
- IDLE:
  - start_mult=1 -> capture a and b, counter=0, go to MULT.
  - start_div=1 with b!=0 -> capture the operand magnitudes and both sign bits, go to DIV.
  - start_div=1 with b==0 -> go to DONE with the div_zero flag set. No iterations are run.
  - start_mult and start_div both high -> the multiply is performed and start_div is ignored.
- Starts are ignored while busy=1. They are not queued.
- MULT:
  - Radix-2 Booth, one step per cycle, WIDTH cycles.
  - Working registers: product {P_hi, P_lo} of 2W bits, plus a Booth extra bit.
  - Each cycle, on the bit pair {P_lo[0], extra}: 01 -> P_hi += A, 10 -> P_hi -= A, 00/11 -> no operation. This is followed by an arithmetic shift right of {P_hi, P_lo, extra}.
  - After the WIDTH-th step, go to DONE.
- DIV:
  - Restoring division on magnitudes, WIDTH cycles.
  - Each cycle: shift {R, Q} left by one, then trial-subtract |B| from R. If the result is non-negative, keep it and set Q[0]=1; otherwise restore R.
  - After the final step, fix up signs. The quotient is negated if sign(a) XOR sign(b). The remainder takes the sign of a, i.e. truncation toward zero.
  - Then go to DONE.
- DONE:
  - Lasts one cycle, with done=1 and busy=1.
  - hi/lo are updated on the edge entering DONE. For a divide by zero, hi/lo keep their previous values and div_zero=1.
  - Next state is IDLE.
- Latency: if a start is sampled at edge k, done is high in the cycle following edge k+WIDTH+1 (33 cycles for WIDTH=32). A divide by zero has done high in the cycle following edge k+1.
- Output holding: hi/lo hold their values from the DONE entry until the next completed operation. They remain readable in IDLE, which is when the control unit asserts HiWrite/LoWrite.
- Overflow: a = -2^(W-1), b = -1 yields lo=0x80000000, hi=0. No flag is raised.
- Back-to-back: a start asserted in the cycle immediately after DONE (state IDLE) is accepted.

Optional Feature:
MULTDIV_UNSIGNED_EN.
- When defined: an extra input is_unsigned (1 bit) is added and captured at start. With is_unsigned=1, the unit implements multu/divu: the multiply uses zero-extended operands with an unsigned shift-and-add (no Booth), and the divide skips the magnitude conversion and the sign fix-up. Latency is unchanged.
- When undefined: the port is absent and all operations are signed.

Test Plan:
1. start_mult, a=7, b=0xFFFFFFFD (-3) -> done after exactly 33 cycles with hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy is high throughout.
2. start_mult, a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
3. start_div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
4. Prior hi=0x11, lo=0x22; start_div, a=5, b=0 -> done and div_zero both pulse 2 cycles after start, and hi/lo stay 0x11/0x22.
5. start_div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then start_mult pulsed mid-divide -> ignored, and only one done is produced.
6. Reset asserted at iteration 10 of a multiply -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows. A new start_mult, a=3, b=4 -> lo=12, hi=0.
